// File: rtl/saa_wr_pkg.sv
// Shared types for the SAA1099 write sequencer: queued write entry and FSM states.
package saa_wr_pkg;
  localparam int CNT_W = 4;

  typedef struct packed {
    logic       a0;
    logic [7:0] data;
  } saa_wr_t;

  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, GAP} saa_wr_state_t;
endpackage

// File: rtl/saa_wr_fifo.sv
// Small synchronous FIFO of queued sound-core writes with a combinational head.
module saa_wr_fifo
  import saa_wr_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                   clk_sys,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  saa_wr_t                din,
  output saa_wr_t                dout,
  output logic [$clog2(DEPTH):0] level,
  output logic                   full
);
  localparam int AW = $clog2(DEPTH);

  saa_wr_t        mem_reg [DEPTH];
  logic [AW:0]    wr_ptr_reg;
  logic [AW:0]    rd_ptr_reg;

  // Extra pointer bit distinguishes full from empty when the indices coincide.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk_sys) begin
    if (push) mem_reg[wr_ptr_reg[AW-1:0]] <= din;
  end

  assign dout  = mem_reg[rd_ptr_reg[AW-1:0]];
  assign level = wr_ptr_reg - rd_ptr_reg;
  assign full  = (level == (AW+1)'(DEPTH));
endmodule

// File: rtl/saa1099_wr_sequencer.sv
// Queues CPU port writes and replays them to the SAA1099 core as paced,
// glitch-free cs_n/wr_n cycles timed on the 8 MHz clock enable.
module saa1099_wr_sequencer
  import saa_wr_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int LOW_CE = 2,
  parameter int GAP_CE = 2
) (
  input  logic                   clk_sys,
  input  logic                   rst_n,
  input  logic                   ce,
  input  logic                   cpu_wr,
  input  logic                   cpu_a0,
  input  logic [7:0]             cpu_din,
  input  logic                   clr_ovf,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level,
  output logic                   ovf,
  output logic                   saa_cs_n,
  output logic                   saa_a0,
  output logic                   saa_wr_n,
  output logic [7:0]             saa_din
);
  saa_wr_state_t    state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             cs_n_reg, cs_n_next;
  logic             wr_n_reg, wr_n_next;
  logic             ovf_reg, ovf_next;
  saa_wr_t          out_reg, out_next;
  saa_wr_t          head;
  logic             pop, push_ok, drop, fifo_empty;

  // A push into a full FIFO still fits when the head leaves in the same cycle.
  assign push_ok    = cpu_wr && (!full || pop);
  assign drop       = cpu_wr && full && !pop;
  assign fifo_empty = (level == '0);

  saa_wr_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_sys (clk_sys),
    .rst_n   (rst_n),
    .push    (push_ok),
    .pop     (pop),
    .din     ({cpu_a0, cpu_din}),
    .dout    (head),
    .level   (level),
    .full    (full)
  );

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      cs_n_reg  <= 1'b1;
      wr_n_reg  <= 1'b1;
      ovf_reg   <= 1'b0;
      out_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      cs_n_reg  <= cs_n_next;
      wr_n_reg  <= wr_n_next;
      ovf_reg   <= ovf_next;
      out_reg   <= out_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    cs_n_next  = cs_n_reg;
    wr_n_next  = wr_n_reg;
    out_next   = out_reg;
    pop        = 1'b0;
    // A drop in the same cycle as a clear must remain visible.
    ovf_next   = drop ? 1'b1 : (clr_ovf ? 1'b0 : ovf_reg);

    unique case (state_reg)
      IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          out_next   = head;
          cs_n_next  = 1'b0;
          state_next = SETUP;
        end
      end
      SETUP: begin
        if (ce) begin
          wr_n_next  = 1'b0;
          cnt_next   = CNT_W'(LOW_CE - 1);
          state_next = STROBE;
        end
      end
      STROBE: begin
        if (ce) begin
          if (cnt_reg == '0) begin
            wr_n_next  = 1'b1;
            state_next = HOLD;
          end else begin
            cnt_next = cnt_reg - CNT_W'(1);
          end
        end
      end
      HOLD: begin
        if (ce) begin
          cs_n_next  = 1'b1;
          cnt_next   = CNT_W'(GAP_CE - 1);
          state_next = GAP;
        end
      end
      GAP: begin
        if (ce) begin
          if (cnt_reg == '0) state_next = IDLE;
          else               cnt_next   = cnt_reg - CNT_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign empty    = fifo_empty && (state_reg == IDLE);
  assign ovf      = ovf_reg;
  assign saa_cs_n = cs_n_reg;
  assign saa_wr_n = wr_n_reg;
  assign saa_a0   = out_reg.a0;
  assign saa_din  = out_reg.data;
endmodule
